// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field constants and FloatAdder status codes.
package fp32_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_EXP_MAX = 255;

  // FloatAdder overflow/status field encoding
  typedef enum logic [1:0] {
    FP_OVF_NONE      = 2'b00,
    FP_OVF_OVERFLOW  = 2'b01,
    FP_OVF_UNDERFLOW = 2'b10,
    FP_OVF_ABNORMAL  = 2'b11
  } fp_ovf_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised single-precision significand.
// The hidden bit is implicit; a mantissa carry-out wraps man to zero and bumps exp.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic [FP_MAN_W-1:0] man_i,
  input  logic                guard_i,
  input  logic                sticky_i,
  input  logic [FP_EXP_W:0]   exp_i,
  output logic [FP_MAN_W-1:0] man_o,
  output logic [FP_EXP_W:0]   exp_o,
  output logic                inexact_o
);

  logic                round_up;
  logic                carry;
  logic [FP_MAN_W-1:0] man_sum;

  // Round up on guard with sticky or odd LSB (ties go to even)
  always_comb begin
    round_up           = guard_i & (sticky_i | man_i[0]);
    {carry, man_sum}   = {1'b0, man_i} + {{FP_MAN_W{1'b0}}, round_up};
    man_o              = man_sum;
    exp_o              = exp_i + {{FP_EXP_W{1'b0}}, carry};
    inexact_o          = guard_i | sticky_i;
  end

endmodule

// File: rtl/int_to_float_conv.sv
// Integer (signed or unsigned) to IEEE-754 single converter.
// Multi-cycle: absolute value, one-bit-per-cycle normalise, RNE round.
module int_to_float_conv
  import fp32_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_inexact
);

  localparam int unsigned EXT_W = IN_WIDTH + 24;
  localparam logic [FP_EXP_W:0] EXP_INIT = (FP_EXP_W+1)'(FP_BIAS + int'(IN_WIDTH) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state_q;
  logic [IN_WIDTH-1:0]   data_q;
  logic                  signed_q;
  logic                  sign_q;
  logic [IN_WIDTH-1:0]   mag_q;
  logic [FP_EXP_W:0]     exp_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [31:0]           out_data_q;
  logic                  out_inexact_q;

  logic                  sign_d;
  logic [IN_WIDTH-1:0]   mag_d;
  logic [EXT_W-1:0]      ext;
  logic [FP_MAN_W-1:0]   rnd_man_in;
  logic                  rnd_guard;
  logic                  rnd_sticky;
  logic [FP_MAN_W-1:0]   rnd_man;
  logic [FP_EXP_W:0]     rnd_exp;
  logic                  rnd_inexact;
  logic                  unused_exp_msb;

  // Magnitude of the captured operand, and mantissa/guard/sticky split of the normalised value.
  // Bits below the hidden bit are left-aligned into a zero-padded field so narrow inputs need no special case.
  always_comb begin
    sign_d     = signed_q & data_q[IN_WIDTH-1];
    mag_d      = sign_d ? -data_q : data_q;
    ext        = {mag_q[IN_WIDTH-2:0], 25'b0};
    rnd_man_in = ext[EXT_W-1 -: FP_MAN_W];
    rnd_guard  = ext[IN_WIDTH];
    rnd_sticky = |ext[IN_WIDTH-1:0];
  end

  fp_round_rne u_round (
    .man_i     (rnd_man_in),
    .guard_i   (rnd_guard),
    .sticky_i  (rnd_sticky),
    .exp_i     (exp_q),
    .man_o     (rnd_man),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  // Biased exponent peaks at 127+32, so bit 8 of the rounded exponent is always zero
  assign unused_exp_msb = rnd_exp[FP_EXP_W];

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      signed_q      <= 1'b0;
      sign_q        <= 1'b0;
      mag_q         <= '0;
      exp_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            signed_q   <= in_signed;
            in_ready_q <= 1'b0;
            state_q    <= S_ABS;
          end
        end
        S_ABS: begin
          sign_q <= sign_d;
          mag_q  <= mag_d;
          exp_q  <= EXP_INIT;
          if (mag_d == '0) begin
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (!mag_q[IN_WIDTH-1]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - (FP_EXP_W+1)'(1);
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_data_q    <= {sign_q, rnd_exp[FP_EXP_W-1:0], rnd_man};
          out_inexact_q <= rnd_inexact;
          out_valid_q   <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Self-checking bench for int_to_float_conv: directed corner cases plus a random sweep
// against an arithmetic reference model (magnitude, leading-one position, RNE on remainder).
module tb_int_to_float_conv;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_inexact;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_data;
  logic        last_inx;
  int          last_lat;

  int_to_float_conv #(.IN_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer value, rounded to 24 significant bits with ties to even
  task automatic model(input logic [31:0] d, input logic s,
                       output logic [31:0] f, output logic inx, output int lat);
    longint v, mag, q, rem, half;
    int     p, sh;
    logic   sg;
    v   = s ? longint'($signed(d)) : longint'(d);
    sg  = (v < 0);
    mag = sg ? -v : v;
    f   = '0;
    inx = 1'b0;
    lat = 2;
    if (mag != 0) begin
      p = 0;
      for (int i = 0; i < 40; i++)
        if (mag >= (longint'(1) << i)) p = i;
      lat = 4 + (31 - p);
      if (p <= 23) begin
        q = mag << (23 - p);
      end else begin
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = longint'(1) << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (longint'(1) << 24)) begin
          q = q >> 1;
          p++;
        end
      end
      f = {sg, 8'(127 + p), q[22:0]};
    end
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_one(input string tag, input logic [31:0] d, input logic s);
    logic [31:0] ef;
    logic        ei;
    int          el, lat;
    send(d, s);
    wait_out(lat);
    model(d, s, ef, ei, el);
    last_data = out_data;
    last_inx  = out_inexact;
    last_lat  = lat;
    chk({tag, "_data"}, out_data, ef);
    chk({tag, "_inexact"}, 32'(out_inexact), 32'(ei));
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    handshake();
  endtask

  initial begin
    logic [31:0] d0, ef;
    logic        i0, ei;
    int          el, lat;
    logic [31:0] rv;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_inexact", 32'(out_inexact), 32'd0);
    @(negedge clk) rst = 1'b1;

    // T1: smallest nonzero, longest normalisation
    run_one("T1", 32'd1, 1'b0);
    chk("T1_lit", last_data, 32'h3F800000);
    chk("T1_lit_lat", 32'(last_lat), 32'd35);

    // T2: signed extremes
    run_one("T2a", 32'hFFFFFFFF, 1'b1);
    chk("T2a_lit", last_data, 32'hBF800000);
    run_one("T2b", 32'h80000000, 1'b1);
    chk("T2b_lit", last_data, 32'hCF000000);
    chk("T2b_lit_inx", 32'(last_inx), 32'd0);

    // T3: zero in both modes gives +0 in 2 cycles
    run_one("T3a", 32'd0, 1'b0);
    chk("T3a_lit_lat", 32'(last_lat), 32'd2);
    run_one("T3b", 32'd0, 1'b1);
    chk("T3b_lit", last_data, 32'h00000000);

    // T4: rounding ties and mantissa carry
    run_one("T4a", 32'd16777217, 1'b0);
    chk("T4a_lit", last_data, 32'h4B800000);
    chk("T4a_lit_inx", 32'(last_inx), 32'd1);
    run_one("T4b", 32'd16777219, 1'b0);
    chk("T4b_lit", last_data, 32'h4B800002);
    run_one("T4c", 32'hFFFFFFFF, 1'b0);
    chk("T4c_lit", last_data, 32'h4F800000);
    chk("T4c_lit_inx", 32'(last_inx), 32'd1);
    run_one("T4d", 32'h7FFFFFFF, 1'b1);

    // T5: backpressure with an ignored input pulse during DONE
    send(32'h12345678, 1'b0);
    wait_out(lat);
    model(32'h12345678, 1'b0, ef, ei, el);
    d0 = out_data;
    i0 = out_inexact;
    chk("T5_data", d0, ef);
    chk("T5_inexact", 32'(i0), 32'(ei));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_data   = 32'h00000005;
        in_signed = 1'b0;
        in_valid  = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("T5_hold_valid", 32'(out_valid), 32'd1);
      chk("T5_hold_data", out_data, d0);
      chk("T5_hold_inx", 32'(out_inexact), 32'(i0));
      chk("T5_in_ready_low", 32'(in_ready), 32'd0);
    end
    handshake();
    repeat (4) @(posedge clk);
    #1;
    chk("T5_no_accept", 32'(out_valid), 32'd0);
    chk("T5_idle_ready", 32'(in_ready), 32'd1);

    // T6: reset during normalisation aborts the conversion
    send(32'd1, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("T6_abort_valid", 32'(out_valid), 32'd0);
    chk("T6_abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("T6_no_result", 32'(out_valid), 32'd0);
    run_one("T6_after", 32'hFFFF8001, 1'b1);

    // Random sweep across both modes and a range of magnitudes
    for (int k = 0; k < 40; k++) begin
      rv = $urandom() >> $urandom_range(0, 31);
      run_one("RND", rv, k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench never hangs
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
